// File: rtl/task_fsm_group_ctrl.sv
// Group start/done controller: one global launch fans out to NUM_TASKS child tasks,
// each re-launched N times, with an aggregated done and a sticky stray-done error.
module task_fsm_group_ctrl #(
  parameter int NUM_TASKS = 4,
  parameter int SCALAR_W  = 96,
  parameter int CNT_W     = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [SCALAR_W-1:0]  global_fsm_scalars,
  input  logic [CNT_W-1:0]     global_fsm_iter_count,
  input  logic [NUM_TASKS-1:0] global_fsm_task_mask,
  input  logic                 global_fsm_ap_start,
  input  logic                 global_fsm_ap_done,
  output logic                 to_global_fsm_is_done,
  output logic [SCALAR_W-1:0]  task_scalars,
  output logic [NUM_TASKS-1:0] task_ap_start,
  input  logic [NUM_TASKS-1:0] task_ap_ready,
  input  logic [NUM_TASKS-1:0] task_ap_done,
  input  logic [NUM_TASKS-1:0] task_ap_idle,
  output logic [NUM_TASKS-1:0] task_done_vec,
  output logic                 err_overrun
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b11;
  localparam logic [1:0] ST_DONE  = 2'b10;

  logic [1:0]           state_q [NUM_TASKS];
  logic [1:0]           state_d [NUM_TASKS];
  logic [CNT_W-1:0]     cnt_q   [NUM_TASKS];
  logic [CNT_W-1:0]     cnt_d   [NUM_TASKS];
  logic [SCALAR_W-1:0]  scalars_q, scalars_d;
  logic [NUM_TASKS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;

  logic [NUM_TASKS-1:0] idle_vec;
  logic [NUM_TASKS-1:0] start_vec;
  logic [NUM_TASKS-1:0] done_vec;
  logic [NUM_TASKS-1:0] stray_vec;
  logic                 all_idle;
  logic                 launch;

  // Per-task idle status is informational; the latched mask is kept for the run but
  // the launch decision itself uses the mask presented on the launch edge.
  logic                 unused_inputs;
  assign unused_inputs = ^{task_ap_idle, mask_q};

  always_comb begin : state_decode
    // NOTE: every variable written in an always_comb gets a default first, so no path
    // can leave it unassigned and infer a latch.
    idle_vec  = '0;
    start_vec = '0;
    done_vec  = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      idle_vec[i]  = (state_q[i] == ST_IDLE);
      start_vec[i] = (state_q[i] == ST_START);
      done_vec[i]  = (state_q[i] == ST_DONE);
    end
  end

  assign all_idle = &idle_vec;
  assign launch   = global_fsm_ap_start & all_idle;

  always_comb begin : launch_regs
    scalars_d = scalars_q;
    mask_d    = mask_q;
    count_d   = count_q;
    if (launch) begin
      scalars_d = global_fsm_scalars;
      mask_d    = global_fsm_task_mask;
      count_d   = (global_fsm_iter_count == '0) ? CNT_W'(1) : global_fsm_iter_count;
    end
  end

  always_comb begin : task_fsm
    logic             complete;
    logic [CNT_W:0]   cnt_inc;
    complete = 1'b0;
    cnt_inc  = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      complete   = 1'b0;
      cnt_inc    = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, 1'b1};
      case (state_q[i])
        ST_IDLE: begin
          if (launch) begin
            state_d[i] = global_fsm_task_mask[i] ? ST_START : ST_DONE;
            cnt_d[i]   = '0;
          end
        end
        ST_START: begin
          if (task_ap_ready[i]) begin
            if (task_ap_done[i]) complete   = 1'b1;
            else                 state_d[i] = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (task_ap_done[i]) complete = 1'b1;
        end
        ST_DONE: begin
          if (global_fsm_ap_done) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
      // Widened compare: cnt never exceeds count-1, so count = 2^CNT_W-1 cannot wrap.
      if (complete) begin
        if (cnt_inc < {1'b0, count_q}) begin
          cnt_d[i]   = cnt_inc[CNT_W-1:0];
          state_d[i] = ST_START;
        end else begin
          state_d[i] = ST_DONE;
        end
      end
    end
  end

  always_comb begin : overrun
    stray_vec = task_ap_done & (idle_vec | done_vec);
    err_d     = err_q | (|stray_vec);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of block ordering.
  // NOTE: the state and counter arrays are reset like any other flop so that a mid-run
  // reset leaves no task able to raise a start after release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_TASKS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      scalars_q <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TASKS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      scalars_q <= scalars_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign task_ap_start         = start_vec;
  assign task_done_vec         = done_vec;
  assign to_global_fsm_is_done = &done_vec;
  assign task_scalars          = scalars_q;
  assign err_overrun           = err_q;

endmodule

// File: tb/tb_task_fsm_group_ctrl.sv
// Bench for task_fsm_group_ctrl: table of group launches served by a task responder,
// with a per-task scoreboard of expected start handshakes, plus hand-written corner cases.
module tb_task_fsm_group_ctrl;

  localparam int NT = 4;
  localparam int SW = 96;
  localparam int CW = 16;

  logic          ap_clk;
  logic          ap_rst_n;
  logic [SW-1:0] global_fsm_scalars;
  logic [CW-1:0] global_fsm_iter_count;
  logic [NT-1:0] global_fsm_task_mask;
  logic          global_fsm_ap_start;
  logic          global_fsm_ap_done;
  logic          to_global_fsm_is_done;
  logic [SW-1:0] task_scalars;
  logic [NT-1:0] task_ap_start;
  logic [NT-1:0] task_ap_ready;
  logic [NT-1:0] task_ap_done;
  logic [NT-1:0] task_ap_idle;
  logic [NT-1:0] task_done_vec;
  logic          err_overrun;

  logic [NT-1:0] resp_ready;
  logic [NT-1:0] resp_done;
  logic [NT-1:0] man_done;

  assign task_ap_ready = resp_ready;
  assign task_ap_done  = resp_done | man_done;
  assign task_ap_idle  = ~task_ap_start;

  task_fsm_group_ctrl #(.NUM_TASKS(NT), .SCALAR_W(SW), .CNT_W(CW)) dut (
    .ap_clk                (ap_clk),
    .ap_rst_n              (ap_rst_n),
    .global_fsm_scalars    (global_fsm_scalars),
    .global_fsm_iter_count (global_fsm_iter_count),
    .global_fsm_task_mask  (global_fsm_task_mask),
    .global_fsm_ap_start   (global_fsm_ap_start),
    .global_fsm_ap_done    (global_fsm_ap_done),
    .to_global_fsm_is_done (to_global_fsm_is_done),
    .task_scalars          (task_scalars),
    .task_ap_start         (task_ap_start),
    .task_ap_ready         (task_ap_ready),
    .task_ap_done          (task_ap_done),
    .task_ap_idle          (task_ap_idle),
    .task_done_vec         (task_done_vec),
    .err_overrun           (err_overrun)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [NT-1:0] mask;
    logic [CW-1:0] count;
    logic [SW-1:0] scalars;
    int            lat;
    int            exp_cyc;
    logic [NT-1:0] exp_dv1;
  } vec_t;

  typedef logic [SW-1:0] sc_t;

  vec_t vecs [7];
  sc_t  sb [NT][$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   resp_lat = 0;
  int   phase [NT];
  int   timer [NT];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Child task model: ready on the first START cycle, done resp_lat cycles later.
  initial begin
    sc_t exp_s;
    resp_ready = '0;
    resp_done  = '0;
    for (int i = 0; i < NT; i++) begin
      phase[i] = 0;
      timer[i] = 0;
    end
    forever begin
      @(posedge ap_clk);
      #1;
      for (int i = 0; i < NT; i++) begin
        if (!ap_rst_n) begin
          phase[i]      = 0;
          resp_ready[i] = 1'b0;
          resp_done[i]  = 1'b0;
        end else if (phase[i] == 1) begin
          resp_ready[i] = 1'b0;
          check("start_pulse_len", 128'(task_ap_start[i]), 128'(0));
          timer[i]--;
          if (timer[i] == 0) begin
            resp_done[i] = 1'b1;
            phase[i]     = 0;
          end
        end else begin
          resp_ready[i] = 1'b0;
          resp_done[i]  = 1'b0;
          if (task_ap_start[i]) begin
            resp_ready[i] = 1'b1;
            if (sb[i].size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL unexpected_start task %0d: got start expected none", i);
            end else begin
              exp_s = sb[i].pop_front();
              check("handshake_scalars", 128'(task_scalars), 128'(exp_s));
            end
            if (resp_lat == 0) resp_done[i] = 1'b1;
            else begin
              timer[i] = resp_lat;
              phase[i] = 1;
            end
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_start"},   128'(task_ap_start),         128'(0));
    check({tag, "_donevec"}, 128'(task_done_vec),         128'(0));
    check({tag, "_isdone"},  128'(to_global_fsm_is_done), 128'(0));
    check({tag, "_scalars"}, 128'(task_scalars),          128'(0));
    check({tag, "_err"},     128'(err_overrun),           128'(0));
  endtask

  // Returns in the cycle right after the launch edge.
  task automatic launch(input logic [NT-1:0] mask, input logic [CW-1:0] count,
                        input logic [SW-1:0] scalars);
    int n;
    @(posedge ap_clk);
    #1;
    global_fsm_task_mask  = mask;
    global_fsm_iter_count = count;
    global_fsm_scalars    = scalars;
    global_fsm_ap_start   = 1'b1;
    n = (count == 0) ? 1 : int'(count);
    for (int i = 0; i < NT; i++)
      if (mask[i]) for (int k = 0; k < n; k++) sb[i].push_back(scalars);
    @(posedge ap_clk);
    #1;
    global_fsm_ap_start  = 1'b0;
    global_fsm_scalars   = ~scalars;
    global_fsm_task_mask = ~mask;
  endtask

  // Waits for is_done (cycle index counted from the launch edge), then acknowledges.
  task automatic wait_done(input string tag, input int first_w, input int exp_w,
                           input logic [NT-1:0] exp_dv1, input logic [SW-1:0] exp_sc);
    int got;
    got = -1;
    for (int w = first_w; w <= first_w + 200; w++) begin
      @(negedge ap_clk);
      if (w == 1) begin
        check({tag, "_donevec_c1"}, 128'(task_done_vec), 128'(exp_dv1));
        check({tag, "_scalars_c1"}, 128'(task_scalars), 128'(exp_sc));
      end
      if (to_global_fsm_is_done) begin
        got = w;
        break;
      end
    end
    check({tag, "_isdone_cycle"}, 128'(got), 128'(exp_w));
    check({tag, "_donevec_all"}, 128'(task_done_vec), 128'({NT{1'b1}}));
    for (int i = 0; i < NT; i++)
      check({tag, "_sb_left"}, 128'(sb[i].size()), 128'(0));
    @(posedge ap_clk);
    #1;
    global_fsm_ap_done = 1'b1;
    @(posedge ap_clk);
    #1;
    global_fsm_ap_done = 1'b0;
    @(negedge ap_clk);
    check({tag, "_ack_idle"}, 128'({task_done_vec, task_ap_start, to_global_fsm_is_done}), 128'(0));
  endtask

  task automatic run_vector(input int idx);
    resp_lat = vecs[idx].lat;
    launch(vecs[idx].mask, vecs[idx].count, vecs[idx].scalars);
    wait_done($sformatf("vec%0d", idx), 1, vecs[idx].exp_cyc, vecs[idx].exp_dv1,
              vecs[idx].scalars);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_start;
    logic [SW-1:0] s1;
    //           mask     count   scalars                             lat cyc dv1
    vecs[0] = '{4'hF,    16'd1, 96'h0000_0040_0000_1000_0000_0080, 5,  7, 4'b0000};
    vecs[1] = '{4'b0001, 16'd3, 96'h1111_2222_3333_4444_5555_6666, 2, 10, 4'b1110};
    vecs[2] = '{4'hF,    16'd0, 96'hDEAD_BEEF_0000_0001_CAFE_F00D, 2,  4, 4'b0000};
    vecs[3] = '{4'b0101, 16'd2, 96'hA5A5_A5A5_5A5A_5A5A_0F0F_F0F0, 1,  5, 4'b1010};
    vecs[4] = '{4'b0000, 16'd5, 96'h0123_4567_89AB_CDEF_FEDC_BA98, 3,  1, 4'b1111};
    vecs[5] = '{4'hF,    16'd1, 96'h7777_0000_8888_0000_9999_0000, 0,  2, 4'b0000};
    vecs[6] = '{4'b1010, 16'd4, 96'h0000_0000_0000_0000_0000_ABCD, 0,  5, 4'b0101};

    man_done              = '0;
    global_fsm_scalars    = '0;
    global_fsm_iter_count = '0;
    global_fsm_task_mask  = '0;
    global_fsm_ap_start   = 1'b0;
    global_fsm_ap_done    = 1'b0;
    ap_rst_n              = 1'b0;
    #3;
    check_all_zero("reset");
    #20;
    ap_rst_n = 1'b1;

    for (int v = 0; v < 7; v++) run_vector(v);
    check("err_clean_runs", 128'(err_overrun), 128'(0));

    // A second start during an active run must be ignored.
    s1       = 96'h0000_0040_0000_2000_0000_0100;
    resp_lat = 8;
    launch(4'b0001, 16'd1, s1);
    @(posedge ap_clk);
    #1;
    global_fsm_ap_start  = 1'b1;
    global_fsm_task_mask = 4'hF;
    global_fsm_scalars   = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    @(posedge ap_clk);
    #1;
    global_fsm_ap_start = 1'b0;
    @(negedge ap_clk);
    check("relaunch_scalars", 128'(task_scalars), 128'(s1));
    check("relaunch_start", 128'(task_ap_start), 128'(0));
    wait_done("relaunch", 4, 10, 4'b0000, s1);

    // Stray done from an idle task.
    @(posedge ap_clk);
    #1;
    man_done = 4'b0100;
    @(posedge ap_clk);
    #1;
    man_done = '0;
    @(negedge ap_clk);
    check("stray_err", 128'(err_overrun), 128'(1));
    check("stray_fsm", 128'({task_done_vec, task_ap_start, to_global_fsm_is_done}), 128'(0));
    repeat (3) @(negedge ap_clk);
    check("stray_err_sticky", 128'(err_overrun), 128'(1));

    // Asynchronous reset between clock edges while tasks sit in WAIT.
    resp_lat = 8;
    launch(4'hF, 16'd1, 96'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD);
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    check("midwait_start", 128'(task_ap_start), 128'(0));
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    for (int i = 0; i < NT; i++) sb[i].delete();
    @(posedge ap_clk);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n   = 1'b1;
    seen_start = 1'b0;
    repeat (6) begin
      @(negedge ap_clk);
      seen_start = seen_start | (|task_ap_start);
    end
    check("no_start_after_reset", 128'(seen_start), 128'(0));
    check("post_reset_donevec", 128'(task_done_vec), 128'(0));

    run_vector(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
